// File: rtl/id_ex_stage_if.sv
// ID/EX stage bus: decoded ID fields, MEM/WB forward sources, and EX-side outputs.
// master = pipeline/testbench driving ID, slave = id_ex_stage.
interface id_ex_stage_if;
  logic        stall;
  logic        flush;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_rs_val;
  logic [31:0] id_rt_val;
  logic [31:0] id_imm;
  logic [4:0]  id_shamt;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic [4:0]  id_rd;
  logic        id_uses_rs;
  logic        id_uses_rt;
  logic        id_alusrc;
  logic        id_shamt_sel;
  logic        id_link;
  logic [4:0]  id_aluop;
  logic [2:0]  id_branchop;
  logic        id_regwrite;
  logic        id_memread;
  logic        id_memwrite;
  logic        mem_regwrite;
  logic [4:0]  mem_rd;
  logic [31:0] mem_result;
  logic        wb_regwrite;
  logic [4:0]  wb_rd;
  logic [31:0] wb_result;
  logic [31:0] ex_op1;
  logic [31:0] ex_op2;
  logic [4:0]  ex_aluop;
  logic [2:0]  ex_branchop;
  logic [31:0] ex_store_data;
  logic [4:0]  ex_rd;
  logic [31:0] ex_pc;
  logic        ex_valid;
  logic        ex_regwrite;
  logic        ex_memread;
  logic        ex_memwrite;
  logic        load_use;

  modport master (
    output stall, flush, id_valid, id_pc, id_rs_val, id_rt_val, id_imm, id_shamt,
           id_rs, id_rt, id_rd, id_uses_rs, id_uses_rt, id_alusrc, id_shamt_sel,
           id_link, id_aluop, id_branchop, id_regwrite, id_memread, id_memwrite,
           mem_regwrite, mem_rd, mem_result, wb_regwrite, wb_rd, wb_result,
    input  ex_op1, ex_op2, ex_aluop, ex_branchop, ex_store_data, ex_rd, ex_pc,
           ex_valid, ex_regwrite, ex_memread, ex_memwrite, load_use
  );

  modport slave (
    input  stall, flush, id_valid, id_pc, id_rs_val, id_rt_val, id_imm, id_shamt,
           id_rs, id_rt, id_rd, id_uses_rs, id_uses_rt, id_alusrc, id_shamt_sel,
           id_link, id_aluop, id_branchop, id_regwrite, id_memread, id_memwrite,
           mem_regwrite, mem_rd, mem_result, wb_regwrite, wb_rd, wb_result,
    output ex_op1, ex_op2, ex_aluop, ex_branchop, ex_store_data, ex_rd, ex_pc,
           ex_valid, ex_regwrite, ex_memread, ex_memwrite, load_use
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with MEM/WB operand forwarding and load-use detection.
// Optional WB-stage forwarding is enabled by defining IDEX_WB_FWD_EN.
module id_ex_stage (
  input logic          clk,
  input logic          reset_n,
  id_ex_stage_if.slave bus
);
  localparam logic [2:0] BO_NONE = 3'd7;

  logic        valid_q;
  logic [31:0] pc_q;
  logic [31:0] rs_val_q;
  logic [31:0] rt_val_q;
  logic [31:0] imm_q;
  logic [4:0]  shamt_q;
  logic [4:0]  rs_q;
  logic [4:0]  rt_q;
  logic [4:0]  rd_q;
  logic        alusrc_q;
  logic        shamt_sel_q;
  logic        link_q;
  logic [4:0]  aluop_q;
  logic [2:0]  branchop_q;
  logic        regwrite_q;
  logic        memread_q;
  logic        memwrite_q;

  logic        load_use_c;
  logic [31:0] rs_fwd_c;
  logic [31:0] rt_fwd_c;

  // A load in EX whose destination is read by the ID instruction forces one bubble.
  always_comb begin
    load_use_c = 1'b0;
    if (!bus.stall && valid_q && memread_q && (rd_q != 5'd0) && bus.id_valid &&
        ((bus.id_uses_rs && (bus.id_rs == rd_q)) ||
         (bus.id_uses_rt && (bus.id_rt == rd_q))))
      load_use_c = 1'b1;
  end

  // Stage register: reset, then stall hold, then bubble, then capture.
  always_ff @(posedge clk) begin
    if (!reset_n || (!bus.stall && (bus.flush || load_use_c))) begin
      valid_q     <= 1'b0;
      pc_q        <= 32'd0;
      rs_val_q    <= 32'd0;
      rt_val_q    <= 32'd0;
      imm_q       <= 32'd0;
      shamt_q     <= 5'd0;
      rs_q        <= 5'd0;
      rt_q        <= 5'd0;
      rd_q        <= 5'd0;
      alusrc_q    <= 1'b0;
      shamt_sel_q <= 1'b0;
      link_q      <= 1'b0;
      aluop_q     <= 5'd0;
      branchop_q  <= BO_NONE;
      regwrite_q  <= 1'b0;
      memread_q   <= 1'b0;
      memwrite_q  <= 1'b0;
    end else if (!bus.stall) begin
      valid_q     <= bus.id_valid;
      pc_q        <= bus.id_pc;
      rs_val_q    <= bus.id_rs_val;
      rt_val_q    <= bus.id_rt_val;
      imm_q       <= bus.id_imm;
      shamt_q     <= bus.id_shamt;
      rs_q        <= bus.id_rs;
      rt_q        <= bus.id_rt;
      rd_q        <= bus.id_rd;
      alusrc_q    <= bus.id_alusrc;
      shamt_sel_q <= bus.id_shamt_sel;
      link_q      <= bus.id_link;
      aluop_q     <= bus.id_aluop;
      branchop_q  <= bus.id_branchop;
      regwrite_q  <= bus.id_regwrite;
      memread_q   <= bus.id_memread;
      memwrite_q  <= bus.id_memwrite;
    end
  end

  // Forward selection; MEM beats WB and register 0 is never forwarded.
  always_comb begin
    rs_fwd_c = rs_val_q;
    rt_fwd_c = rt_val_q;
    if (bus.mem_regwrite && (bus.mem_rd == rs_q) && (rs_q != 5'd0))
      rs_fwd_c = bus.mem_result;
`ifdef IDEX_WB_FWD_EN
    else if (bus.wb_regwrite && (bus.wb_rd == rs_q) && (rs_q != 5'd0))
      rs_fwd_c = bus.wb_result;
`endif
    if (bus.mem_regwrite && (bus.mem_rd == rt_q) && (rt_q != 5'd0))
      rt_fwd_c = bus.mem_result;
`ifdef IDEX_WB_FWD_EN
    else if (bus.wb_regwrite && (bus.wb_rd == rt_q) && (rt_q != 5'd0))
      rt_fwd_c = bus.wb_result;
`endif
  end

`ifndef IDEX_WB_FWD_EN
  logic unused_wb;
  assign unused_wb = ^{bus.wb_regwrite, bus.wb_rd, bus.wb_result};
`endif

  assign bus.ex_op1        = link_q ? pc_q : (shamt_sel_q ? {27'd0, shamt_q} : rs_fwd_c);
  assign bus.ex_op2        = link_q ? 32'd8 : (alusrc_q ? imm_q : rt_fwd_c);
  assign bus.ex_store_data = rt_fwd_c;
  assign bus.ex_aluop      = aluop_q;
  assign bus.ex_branchop   = branchop_q;
  assign bus.ex_rd         = rd_q;
  assign bus.ex_pc         = pc_q;
  assign bus.ex_valid      = valid_q;
  assign bus.ex_regwrite   = regwrite_q;
  assign bus.ex_memread    = memread_q;
  assign bus.ex_memwrite   = memwrite_q;
  assign bus.load_use      = load_use_c;
endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus randomized traffic
// against a behavioural model of the stage contents.
module tb_id_ex_stage;
  localparam logic [2:0] BO_NONE = 3'd7;

  logic clk = 1'b0;
  logic reset_n;
  int   errors = 0;
  int   checks = 0;

  id_ex_stage_if bus ();
  id_ex_stage dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  always #5 clk = ~clk;

  // Model of what the stage currently holds.
  logic        m_valid, m_alusrc, m_shamt_sel, m_link, m_regwrite, m_memread, m_memwrite;
  logic [31:0] m_pc, m_rs_val, m_rt_val, m_imm;
  logic [4:0]  m_shamt, m_rs, m_rt, m_rd, m_aluop;
  logic [2:0]  m_branchop;

  function automatic logic [31:0] fwd(input logic [4:0] src, input logic [31:0] rv);
    if (src != 5'd0 && bus.mem_regwrite && bus.mem_rd == src) return bus.mem_result;
`ifdef IDEX_WB_FWD_EN
    if (src != 5'd0 && bus.wb_regwrite && bus.wb_rd == src) return bus.wb_result;
`endif
    return rv;
  endfunction

  function automatic logic [31:0] exp_op1();
    if (m_link) return m_pc;
    if (m_shamt_sel) return 32'(m_shamt);
    return fwd(m_rs, m_rs_val);
  endfunction

  function automatic logic [31:0] exp_op2();
    if (m_link) return 32'd8;
    if (m_alusrc) return m_imm;
    return fwd(m_rt, m_rt_val);
  endfunction

  function automatic logic exp_lu();
    if (bus.stall || !m_valid || !m_memread || m_rd == 5'd0 || !bus.id_valid) return 1'b0;
    return (bus.id_uses_rs && bus.id_rs == m_rd) || (bus.id_uses_rt && bus.id_rt == m_rd);
  endfunction

  task automatic model_bubble();
    m_valid = 0; m_pc = 0; m_rs_val = 0; m_rt_val = 0; m_imm = 0; m_shamt = 0;
    m_rs = 0; m_rt = 0; m_rd = 0; m_alusrc = 0; m_shamt_sel = 0; m_link = 0;
    m_aluop = 0; m_branchop = BO_NONE; m_regwrite = 0; m_memread = 0; m_memwrite = 0;
  endtask

  // One clock edge with the model updated by the stage's priority rules.
  task automatic tick();
    logic lu;
    lu = exp_lu();
    @(posedge clk);
    if (!reset_n) model_bubble();
    else if (bus.stall) begin end
    else if (bus.flush || lu) model_bubble();
    else begin
      m_valid = bus.id_valid; m_pc = bus.id_pc; m_rs_val = bus.id_rs_val;
      m_rt_val = bus.id_rt_val; m_imm = bus.id_imm; m_shamt = bus.id_shamt;
      m_rs = bus.id_rs; m_rt = bus.id_rt; m_rd = bus.id_rd; m_alusrc = bus.id_alusrc;
      m_shamt_sel = bus.id_shamt_sel; m_link = bus.id_link; m_aluop = bus.id_aluop;
      m_branchop = bus.id_branchop; m_regwrite = bus.id_regwrite;
      m_memread = bus.id_memread; m_memwrite = bus.id_memwrite;
    end
    #1;
  endtask

  task automatic clear_inputs();
    bus.stall = 0; bus.flush = 0; bus.id_valid = 0; bus.id_pc = 0; bus.id_rs_val = 0;
    bus.id_rt_val = 0; bus.id_imm = 0; bus.id_shamt = 0; bus.id_rs = 0; bus.id_rt = 0;
    bus.id_rd = 0; bus.id_uses_rs = 0; bus.id_uses_rt = 0; bus.id_alusrc = 0;
    bus.id_shamt_sel = 0; bus.id_link = 0; bus.id_aluop = 0; bus.id_branchop = 0;
    bus.id_regwrite = 0; bus.id_memread = 0; bus.id_memwrite = 0;
    bus.mem_regwrite = 0; bus.mem_rd = 0; bus.mem_result = 0;
    bus.wb_regwrite = 0; bus.wb_rd = 0; bus.wb_result = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset_n = 0;
    tick(); tick();
    checks++;
    if ({bus.ex_op1, bus.ex_op2, bus.ex_store_data, bus.ex_pc} !== 128'd0) begin
      errors++; $display("FAIL reset_data got %h/%h/%h/%h want 0", bus.ex_op1, bus.ex_op2, bus.ex_store_data, bus.ex_pc);
    end
    checks++;
    if ({bus.ex_valid, bus.ex_regwrite, bus.ex_memread, bus.ex_memwrite, bus.ex_rd, bus.ex_aluop, bus.load_use} !== 15'd0
        || bus.ex_branchop !== BO_NONE) begin
      errors++; $display("FAIL reset_ctrl got v%b rd%0d alu%0d bo%0d lu%b want zeros bo%0d",
                         bus.ex_valid, bus.ex_rd, bus.ex_aluop, bus.ex_branchop, bus.load_use, BO_NONE);
    end
    reset_n = 1;
    tick();
  endtask

  task automatic test_mem_forward();
    clear_inputs();
    bus.id_valid = 1; bus.id_rs = 5; bus.id_rt = 6; bus.id_rs_val = 32'h1111;
    bus.id_rt_val = 32'h2222; bus.id_aluop = 5'd1; bus.id_regwrite = 1; bus.id_rd = 8;
    tick();
    bus.id_valid = 0;
    bus.mem_regwrite = 1; bus.mem_rd = 5; bus.mem_result = 32'h1234; #1;
    checks++;
    if (bus.ex_op1 !== 32'h1234) begin errors++; $display("FAIL mem_fwd got %h want 00001234", bus.ex_op1); end
    checks++;
    if (bus.ex_op2 !== 32'h2222) begin errors++; $display("FAIL mem_fwd_rt_nomatch got %h want 00002222", bus.ex_op2); end
    bus.mem_result = 32'hA; bus.wb_regwrite = 1; bus.wb_rd = 5; bus.wb_result = 32'hB; #1;
    checks++;
    if (bus.ex_op1 !== 32'hA) begin errors++; $display("FAIL mem_over_wb got %h want a", bus.ex_op1); end
    bus.mem_regwrite = 0; #1;
    checks++;
`ifdef IDEX_WB_FWD_EN
    if (bus.ex_op1 !== 32'hB) begin errors++; $display("FAIL wb_fwd got %h want b", bus.ex_op1); end
`else
    if (bus.ex_op1 !== 32'h1111) begin errors++; $display("FAIL wb_nofwd got %h want 1111", bus.ex_op1); end
`endif
    bus.wb_rd = 6; bus.wb_result = 32'hC; bus.mem_regwrite = 1; bus.mem_rd = 6; bus.mem_result = 32'hD; #1;
    checks++;
    if (bus.ex_store_data !== 32'hD || bus.ex_op2 !== 32'hD) begin
      errors++; $display("FAIL store_fwd got %h/%h want d", bus.ex_store_data, bus.ex_op2);
    end
    bus.id_valid = 1; bus.id_rs = 0; bus.id_rs_val = 32'h55;
    tick();
    bus.mem_regwrite = 1; bus.mem_rd = 0; bus.mem_result = 32'hDEAD;
    bus.wb_regwrite = 1; bus.wb_rd = 0; #1;
    checks++;
    if (bus.ex_op1 !== 32'h55) begin errors++; $display("FAIL reg0_nofwd got %h want 55", bus.ex_op1); end
    clear_inputs(); tick();
  endtask

  task automatic test_load_use();
    clear_inputs();
    bus.id_valid = 1; bus.id_memread = 1; bus.id_regwrite = 1; bus.id_rd = 4; bus.id_alusrc = 1;
    tick();
    clear_inputs();
    bus.id_valid = 1; bus.id_rs = 4; bus.id_uses_rs = 1; bus.id_rt = 2; bus.id_uses_rt = 1;
    bus.id_rd = 6; bus.id_regwrite = 1; bus.id_pc = 32'h40; #1;
    checks++;
    if (bus.load_use !== 1'b1) begin errors++; $display("FAIL load_use_hit got %b want 1", bus.load_use); end
    tick();
    checks++;
    if ({bus.ex_valid, bus.ex_regwrite, bus.load_use} !== 3'b000) begin
      errors++; $display("FAIL load_use_bubble got v%b rw%b lu%b want 000", bus.ex_valid, bus.ex_regwrite, bus.load_use);
    end
    tick();
    checks++;
    if (bus.ex_valid !== 1'b1 || bus.ex_rd !== 5'd6 || bus.ex_pc !== 32'h40) begin
      errors++; $display("FAIL load_use_capture got v%b rd%0d pc%h want 1/6/40", bus.ex_valid, bus.ex_rd, bus.ex_pc);
    end
    clear_inputs(); tick();
  endtask

  task automatic test_stall_flush();
    clear_inputs();
    bus.id_valid = 1; bus.id_pc = 32'h100; bus.id_rd = 7; bus.id_aluop = 5'd3;
    bus.id_branchop = 3'd2; bus.id_regwrite = 1;
    tick();
    bus.id_pc = 32'h200; bus.id_rd = 9; bus.stall = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bus.ex_pc !== 32'h100 || bus.ex_rd !== 5'd7 || bus.ex_aluop !== 5'd3 || bus.ex_branchop !== 3'd2) begin
        errors++; $display("FAIL stall_hold[%0d] got pc%h rd%0d alu%0d bo%0d want 100/7/3/2",
                           i, bus.ex_pc, bus.ex_rd, bus.ex_aluop, bus.ex_branchop);
      end
    end
    bus.flush = 1;
    tick();
    checks++;
    if (bus.ex_valid !== 1'b1 || bus.ex_pc !== 32'h100) begin
      errors++; $display("FAIL stall_flush_hold got v%b pc%h want 1/100", bus.ex_valid, bus.ex_pc);
    end
    bus.stall = 0;
    tick();
    checks++;
    if ({bus.ex_valid, bus.ex_regwrite, bus.ex_rd, bus.ex_aluop} !== 12'd0 || bus.ex_branchop !== BO_NONE) begin
      errors++; $display("FAIL flush_bubble got v%b rw%b rd%0d bo%0d want 0/0/0/%0d",
                         bus.ex_valid, bus.ex_regwrite, bus.ex_rd, bus.ex_branchop, BO_NONE);
    end
    clear_inputs(); tick();
  endtask

  task automatic test_link_shamt();
    clear_inputs();
    bus.id_valid = 1; bus.id_link = 1; bus.id_pc = 32'h400; bus.id_rd = 31; bus.id_regwrite = 1;
    bus.id_rs_val = 32'h77; bus.id_rt_val = 32'h88;
    tick();
    checks++;
    if (bus.ex_op1 !== 32'h400 || bus.ex_op2 !== 32'd8) begin
      errors++; $display("FAIL link got %h/%h want 400/8", bus.ex_op1, bus.ex_op2);
    end
    clear_inputs();
    bus.id_valid = 1; bus.id_shamt_sel = 1; bus.id_shamt = 7; bus.id_rt = 3; bus.id_rt_val = 32'h99;
    bus.id_rs_val = 32'hFFFF_FFFF;
    tick();
    checks++;
    if (bus.ex_op1 !== 32'd7 || bus.ex_op2 !== 32'h99) begin
      errors++; $display("FAIL shamt got %h/%h want 7/99", bus.ex_op1, bus.ex_op2);
    end
    bus.mem_regwrite = 1; bus.mem_rd = 3; bus.mem_result = 32'h3C; #1;
    checks++;
    if (bus.ex_op2 !== 32'h3C) begin errors++; $display("FAIL shamt_rtfwd got %h want 3c", bus.ex_op2); end
    clear_inputs(); tick();
  endtask

  task automatic test_reset_mid();
    clear_inputs();
    bus.id_valid = 1; bus.id_pc = 32'h500; bus.id_rd = 3; bus.id_memread = 1; bus.id_rs_val = 32'h9;
    tick();
    bus.stall = 1; reset_n = 0;
    tick();
    checks++;
    if ({bus.ex_valid, bus.ex_memread, bus.ex_rd, bus.ex_pc, bus.ex_op1} !== 71'd0 || bus.ex_branchop !== BO_NONE) begin
      errors++; $display("FAIL reset_mid got v%b mr%b rd%0d pc%h bo%0d want cleared",
                         bus.ex_valid, bus.ex_memread, bus.ex_rd, bus.ex_pc, bus.ex_branchop);
    end
    reset_n = 1; clear_inputs(); tick();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      bus.stall = ($urandom_range(0, 7) == 0); bus.flush = ($urandom_range(0, 9) == 0);
      bus.id_valid = $urandom_range(0, 1); bus.id_pc = $urandom; bus.id_rs_val = $urandom;
      bus.id_rt_val = $urandom; bus.id_imm = $urandom; bus.id_shamt = 5'($urandom);
      bus.id_rs = 5'($urandom_range(0, 3)); bus.id_rt = 5'($urandom_range(0, 3));
      bus.id_rd = 5'($urandom_range(0, 3)); bus.id_uses_rs = $urandom_range(0, 1);
      bus.id_uses_rt = $urandom_range(0, 1); bus.id_alusrc = $urandom_range(0, 1);
      bus.id_shamt_sel = ($urandom_range(0, 3) == 0); bus.id_link = ($urandom_range(0, 5) == 0);
      bus.id_aluop = 5'($urandom); bus.id_branchop = 3'($urandom);
      bus.id_regwrite = $urandom_range(0, 1); bus.id_memread = ($urandom_range(0, 2) == 0);
      bus.id_memwrite = $urandom_range(0, 1);
      bus.mem_regwrite = $urandom_range(0, 1); bus.mem_rd = 5'($urandom_range(0, 3)); bus.mem_result = $urandom;
      bus.wb_regwrite = $urandom_range(0, 1); bus.wb_rd = 5'($urandom_range(0, 3)); bus.wb_result = $urandom;
      #1;
      checks++;
      if (bus.ex_op1 !== exp_op1()) begin errors++; $display("FAIL rnd_op1[%0d] got %h want %h", n, bus.ex_op1, exp_op1()); end
      checks++;
      if (bus.ex_op2 !== exp_op2()) begin errors++; $display("FAIL rnd_op2[%0d] got %h want %h", n, bus.ex_op2, exp_op2()); end
      checks++;
      if (bus.ex_store_data !== fwd(m_rt, m_rt_val)) begin
        errors++; $display("FAIL rnd_store[%0d] got %h want %h", n, bus.ex_store_data, fwd(m_rt, m_rt_val));
      end
      checks++;
      if (bus.load_use !== exp_lu()) begin errors++; $display("FAIL rnd_load_use[%0d] got %b want %b", n, bus.load_use, exp_lu()); end
      checks++;
      if ({bus.ex_valid, bus.ex_regwrite, bus.ex_memread, bus.ex_memwrite, bus.ex_aluop, bus.ex_branchop, bus.ex_rd, bus.ex_pc} !==
          {m_valid, m_regwrite, m_memread, m_memwrite, m_aluop, m_branchop, m_rd, m_pc}) begin
        errors++; $display("FAIL rnd_ctrl[%0d] got v%b rd%0d alu%0d bo%0d pc%h want v%b rd%0d alu%0d bo%0d pc%h", n,
                           bus.ex_valid, bus.ex_rd, bus.ex_aluop, bus.ex_branchop, bus.ex_pc,
                           m_valid, m_rd, m_aluop, m_branchop, m_pc);
      end
      tick();
    end
  endtask

  initial begin
    model_bubble();
    reset_n = 0;
    test_reset();
    test_mem_forward();
    test_load_use();
    test_stall_flush();
    test_link_shamt();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register with operand forwarding and load-use hazard detection. It sits directly upstream of the EX-stage ALU. It captures decoded fields from ID each cycle and resolves forwarded register values from MEM and WB. It drives the ALU's `op1`, `op2`, `aluop` and `branchOp` inputs, plus the control bits that travel on to EX/MEM.

## Interface
- No parameters; widths fixed (32-bit datapath, 5-bit register indices, 5-bit `aluop`, 3-bit `branchOp` encoded per `defs.v`).
- `clk` in 1: rising-edge clock, the only clock.
- `reset_n` in 1: synchronous, active-low reset.
- `stall` in 1: downstream hold; stage keeps its contents.
- `flush` in 1: discard the ID instruction; insert a bubble.
- `id_valid` in 1: the ID instruction is real.
- `id_pc` in 32: PC of the ID instruction.
- `id_rs_val`, `id_rt_val` in 32 each: register-file read data.
- `id_imm` in 32: extended immediate.
- `id_shamt` in 5: shamt field.
- `id_rs`, `id_rt`, `id_rd` in 5 each: source and destination indices.
- `id_uses_rs`, `id_uses_rt` in 1 each: operand actually read.
- `id_alusrc` in 1: `op2` comes from the immediate.
- `id_shamt_sel` in 1: `op1` comes from the shamt field.
- `id_link` in 1: `op1 = pc`, `op2 = 8`.
- `id_aluop` in 5, `id_branchop` in 3: ALU and branch opcodes.
- `id_regwrite`, `id_memread`, `id_memwrite` in 1 each: control bits.
- `mem_regwrite` in 1, `mem_rd` in 5, `mem_result` in 32: MEM-stage forward source.
- `wb_regwrite` in 1, `wb_rd` in 5, `wb_result` in 32: WB-stage forward source.
- `ex_op1`, `ex_op2` out 32: ALU operands.
- `ex_aluop` out 5, `ex_branchop` out 3: ALU opcodes.
- `ex_store_data` out 32: forwarded rt value for stores.
- `ex_rd` out 5, `ex_pc` out 32.
- `ex_valid`, `ex_regwrite`, `ex_memread`, `ex_memwrite` out 1 each.
- `load_use` out 1: ID must hold this cycle.

## Operation
- **Registered fields:** all `id_*` fields are held in the stage register and exposed as `ex_*`. `ex_op1`, `ex_op2` and `ex_store_data` are combinational from the registered fields plus the current forward sources.
- **Update priority each edge:**
  1. `!reset_n`: clear.
  2. `stall`: hold everything.
  3. `flush` or `load_use`: load a bubble.
  4. Otherwise capture the ID fields.
- **Bubble:** `ex_valid=0`, `regwrite=memread=memwrite=0`, `branchop=BO_none`, `aluop=0`, indices 0.
- **Forwarding for rs and rt independently:**
  - Use `mem_result` if `mem_regwrite && mem_rd==src && src!=0`.
  - Else use `wb_result` under the same rule (when `IDEX_WB_FWD_EN` is defined).
  - Else use the registered read value.
  - MEM has priority over WB. Register 0 is never forwarded.
- **Operand select:**
  - `op1` = `link ? pc` : `shamt_sel ? {27'b0, shamt}` : `rs_fwd`.
  - `op2` = `link ? 32'd8` : `alusrc ? imm` : `rt_fwd`.
  - `ex_store_data = rt_fwd` always.
  - Variable shifts pass `rs_fwd` as `op1`; the ALU uses `op1[4:0]`.
- **Load-use hazard:** `load_use = ex_valid & ex_memread & ex_rd!=0 & id_valid & ((id_uses_rs & id_rs==ex_rd) | (id_uses_rt & id_rt==ex_rd))`.
  - Combinational; forced 0 while `stall` is high.
  - A single load produces exactly one bubble: the next cycle EX holds the bubble, so `load_use` drops.

## Timing
- **Reset values:** all outputs 0 except `ex_branchop = BO_none`; `load_use = 0`.
- **Capture latency:** one cycle from ID to the `ex_*` register outputs.
- **Forwarding latency:** zero-cycle combinational path from `mem_*`/`wb_*` to `ex_op1`/`ex_op2`.
- **Flush and stall:** `flush` asserted together with `stall` has no effect that cycle. Upstream must hold `flush` until `stall` drops.
- **Reset mid-stall:** reset wins; the stage is cleared.

## Configuration
- **`IDEX_WB_FWD_EN` defined:** WB-stage forwarding is active.
- **`IDEX_WB_FWD_EN` undefined:** only MEM forwarding exists. The register file must then be write-before-read, and the WB compare logic is absent.

## Test plan
- **MEM forward:** EX holds `add` with rs=5; `mem_regwrite=1`, `mem_rd=5`, `mem_result=0x1234` -> `ex_op1=0x1234`.
- **Priority and $0:**
  - Same index in MEM (0xA) and WB (0xB) -> MEM value 0xA.
  - `mem_rd=0` with regwrite -> register value used, not forwarded.
- **Load-use:** `lw $4` in EX, ID `add` reads rs=4 -> `load_use=1` for exactly one cycle. Next edge: `ex_valid=0`, `ex_regwrite=0`. Following edge captures the `add`.
- **Stall vs flush:**
  - `stall=1` for 3 cycles -> all `ex_*` unchanged.
  - `stall=1` with `flush=1` -> hold.
  - Then `flush` alone -> bubble with `ex_branchop=BO_none`.
- **Link and shamt:**
  - `jal` with pc=0x400 -> `op1=0x400`, `op2=8`.
  - `sll` shamt=7 -> `op1=7`, `op2=rt_fwd`.
- **Reset and configuration:**
  - `reset_n=0` mid-operation for one edge -> all outputs at reset values.
  - Without `IDEX_WB_FWD_EN`, a WB match leaves the operand equal to the register-file value.
